// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction words over a
// req/ack memory bus and hands each fetched word plus its PC to decode
// through a registered req/ack handshake. Redirects from execute squash
// any held instruction or in-flight memory read.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic        req_out,
  input  logic        ack_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        branch_in,
  input  logic [31:0] branch_target_in,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;         // next PC to fetch (redirect target after a branch)
  logic [31:0] addr_reg;       // address on the memory bus; lags pc_reg while discarding
  logic [31:0] instr_reg;
  logic [31:0] pc_out_reg;
  logic        req_reg;
  logic        misaligned_reg;

  logic [31:0] branch_pc;
  logic [31:0] pc_plus4;

  // Redirect targets are forced to word alignment; the low bits only feed the pulse.
  assign branch_pc = {branch_target_in[31:2], 2'b00};
  assign pc_plus4  = pc_reg + 32'd4;

  // Control FSM with all decode-facing outputs held in registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      addr_reg       <= RESET_PC;
      instr_reg      <= NOP_INSTR;
      pc_out_reg     <= 32'h0000_0000;
      req_reg        <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      // Pulse only in the cycle after an accepted (non-IDLE) redirect.
      misaligned_reg <= branch_in && (state_reg != IDLE) && (branch_target_in[1:0] != 2'b00);

      case (state_reg)
        IDLE: begin
          addr_reg  <= pc_reg;
          state_reg <= FETCH;
        end

        FETCH: begin
          if (branch_in) begin
            pc_reg <= branch_pc;
            if (imem_ack_in) begin
              // Returned word belongs to the old path: drop it, fetch the target next.
              addr_reg <= branch_pc;
            end else begin
              // Keep the old address on the bus until its ack drains.
              state_reg <= DISCARD;
            end
          end else if (imem_ack_in) begin
            instr_reg  <= imem_rdata_in;
            pc_out_reg <= pc_reg;
            pc_reg     <= pc_plus4;
            addr_reg   <= pc_plus4;
            req_reg    <= 1'b1;
            state_reg  <= HOLD;
          end
        end

        HOLD: begin
          if (branch_in) begin
            // Redirect wins over a same-cycle decode ack: the held word is squashed.
            req_reg   <= 1'b0;
            instr_reg <= NOP_INSTR;
            pc_reg    <= branch_pc;
            addr_reg  <= branch_pc;
            state_reg <= FETCH;
          end else if (ack_in && !stall_in) begin
            req_reg   <= 1'b0;
            instr_reg <= NOP_INSTR;
            state_reg <= FETCH;
          end
        end

        DISCARD: begin
          if (branch_in) begin
            pc_reg <= branch_pc;
          end
          if (imem_ack_in) begin
            // Stale word dropped; resume at the most recent redirect target.
            addr_reg  <= branch_in ? branch_pc : pc_reg;
            state_reg <= FETCH;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign imem_req_out   = (state_reg == FETCH) || (state_reg == DISCARD);
  assign imem_addr_out  = addr_reg;
  assign req_out        = req_reg;
  assign instr_out      = instr_reg;
  assign pc_out         = pc_out_reg;
  assign misaligned_out = misaligned_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory with configurable
// latency, directed decode-side stimulus per scenario, and a scoreboard of
// instructions decode is expected to accept.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        req_out;
  logic        ack_in;
  logic        stall_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        branch_in;
  logic [31:0] branch_target_in;
  logic        misaligned_out;

  // Memory model controls.
  logic mem_on    = 1'b0;
  int   mem_lat   = 0;
  logic force_ack = 1'b0;
  int   wait_cnt  = 0;

  // Scoreboard: exp_q filled by the scenarios, obs_q filled by the acceptance monitor.
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          rd_idx = 0;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_ack_in      (imem_ack_in),
    .imem_rdata_in    (imem_rdata_in),
    .req_out          (req_out),
    .ack_in           (ack_in),
    .stall_in         (stall_in),
    .instr_out        (instr_out),
    .pc_out           (pc_out),
    .branch_in        (branch_in),
    .branch_target_in (branch_target_in),
    .misaligned_out   (misaligned_out)
  );

  always #5 clk = ~clk;

  // Instruction memory: returns addr^KEY after mem_lat waiting cycles.
  initial begin
    imem_ack_in   = 1'b0;
    imem_rdata_in = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (force_ack) begin
        imem_ack_in   = 1'b1;
        imem_rdata_in = 32'hDEAD_BEEF;
        wait_cnt      = 0;
      end else if (mem_on && imem_req_out) begin
        if (wait_cnt >= mem_lat) begin
          imem_ack_in   = 1'b1;
          imem_rdata_in = imem_addr_out ^ KEY;
          wait_cnt      = 0;
        end else begin
          imem_ack_in = 1'b0;
          wait_cnt    = wait_cnt + 1;
        end
      end else begin
        imem_ack_in = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Record every instruction decode actually accepts.
  always @(posedge clk) begin
    if (!reset && req_out && ack_in && !stall_in && !branch_in)
      obs_q.push_back({instr_out, pc_out});
  end

  task automatic apply_reset();
    reset            = 1'b1;
    ack_in           = 1'b0;
    stall_in         = 1'b0;
    branch_in        = 1'b0;
    branch_target_in = 32'h0;
    mem_on           = 1'b0;
    mem_lat          = 0;
    force_ack        = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ack_in = 1'b0; stall_in = 1'b0; branch_in = 1'b0;
    branch_target_in = 32'h0; mem_on = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req_out !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %b want 0", imem_req_out); end
    checks++; if (imem_addr_out !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 00000000", imem_addr_out); end
    checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", req_out); end
    checks++; if (instr_out !== NOP) begin failures++; $display("FAIL reset_instr: got %h want %h", instr_out, NOP); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out: got %h want 00000000", pc_out); end
    checks++; if (misaligned_out !== 1'b0) begin failures++; $display("FAIL reset_misaligned: got %b want 0", misaligned_out); end
    // A branch during the IDLE cycle must be ignored.
    reset = 1'b0; branch_in = 1'b1; branch_target_in = 32'h0000_0401;
    @(negedge clk);
    branch_in = 1'b0;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0 || misaligned_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_branch_ignored: got req=%b addr=%h mis=%b want req=1 addr=00000000 mis=0",
               imem_req_out, imem_addr_out, misaligned_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    apply_reset();
    mem_on = 1'b1; ack_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (k % 2 == 1) begin
        a = 32'((k - 1) / 2 * 4);
        exp_q.push_back({a ^ KEY, a});
        if (imem_req_out !== 1'b1 || imem_addr_out !== a || req_out !== 1'b0) begin
          failures++;
          $display("FAIL seq_fetch_k%0d: got req=%b addr=%h req_out=%b want req=1 addr=%h req_out=0",
                   k, imem_req_out, imem_addr_out, req_out, a);
        end
      end else begin
        a = 32'((k - 2) / 2 * 4);
        if (imem_req_out !== 1'b0 || req_out !== 1'b1 || pc_out !== a || instr_out !== (a ^ KEY)) begin
          failures++;
          $display("FAIL seq_hold_k%0d: got req=%b req_out=%b pc=%h instr=%h want req=0 req_out=1 pc=%h instr=%h",
                   k, imem_req_out, req_out, pc_out, instr_out, a, a ^ KEY);
        end
      end
    end
    @(negedge clk);
    ack_in = 1'b0; mem_on = 1'b0;
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      failures++;
      $display("FAIL seq_count: got %0d accepted want %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++; $display("FAIL seq_sb: got nothing want instr/pc %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin failures++; $display("FAIL seq_sb: got instr/pc %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_q.size();
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    apply_reset();
    mem_on = 1'b1;
    @(negedge clk);                       // FETCH 0, acked at once
    @(negedge clk);                       // HOLD 0
    exp_q.push_back({32'h0 ^ KEY, 32'h0});
    for (int k = 2; k <= 9; k++) begin
      if (k > 2) @(negedge clk);
      checks++;
      if (req_out !== 1'b1 || instr_out !== KEY || pc_out !== 32'h0 || imem_req_out !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_k%0d: got req_out=%b instr=%h pc=%h imem_req=%b want 1 %h 00000000 0",
                 k, req_out, instr_out, pc_out, imem_req_out, KEY);
      end
      ack_in   = (k >= 7);
      stall_in = (k == 7 || k == 8);
    end
    @(negedge clk);
    ack_in = 1'b0; stall_in = 1'b0;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h4 || req_out !== 1'b0 || instr_out !== NOP) begin
      failures++;
      $display("FAIL stall_release: got req=%b addr=%h req_out=%b instr=%h want 1 00000004 0 %h",
               imem_req_out, imem_addr_out, req_out, instr_out, NOP);
    end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      failures++;
      $display("FAIL stall_count: got %0d accepted want %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++; $display("FAIL stall_sb: got nothing want instr/pc %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin failures++; $display("FAIL stall_sb: got instr/pc %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_q.size();
    $display("test_stall done");
  endtask

  task automatic test_branch_hold();
    apply_reset();
    mem_on = 1'b1;
    @(negedge clk);
    @(negedge clk);                       // HOLD with word at 0
    checks++;
    if (req_out !== 1'b1) begin failures++; $display("FAIL bhold_pre: got req_out=%b want 1", req_out); end
    branch_in = 1'b1; branch_target_in = 32'h0000_0100; ack_in = 1'b1;
    @(negedge clk);
    branch_in = 1'b0; ack_in = 1'b0;
    checks++;
    if (req_out !== 1'b0 || instr_out !== NOP || imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin
      failures++;
      $display("FAIL bhold_redirect: got req_out=%b instr=%h req=%b addr=%h want 0 %h 1 00000100",
               req_out, instr_out, imem_req_out, imem_addr_out, NOP);
    end
    @(negedge clk);
    checks++;
    if (req_out !== 1'b1 || pc_out !== 32'h100) begin
      failures++; $display("FAIL bhold_target: got req_out=%b pc=%h want 1 00000100", req_out, pc_out);
    end
    exp_q.push_back({32'h100 ^ KEY, 32'h100});
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      failures++;
      $display("FAIL bhold_count: got %0d accepted want %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++; $display("FAIL bhold_sb: got nothing want instr/pc %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin failures++; $display("FAIL bhold_sb: got instr/pc %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_q.size();
    $display("test_branch_hold done");
  endtask

  task automatic test_branch_discard();
    logic [31:0] a;
    apply_reset();
    mem_on = 1'b1; mem_lat = 3;
    @(negedge clk);                       // FETCH cycle 1, address 0
    branch_in = 1'b1; branch_target_in = 32'h0000_0200;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      branch_in = 1'b0;
      a = (k <= 4) ? 32'h0 : 32'h200;
      checks++;
      if (req_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== a) begin
        failures++;
        $display("FAIL discard_k%0d: got req_out=%b req=%b addr=%h want 0 1 %h",
                 k, req_out, imem_req_out, imem_addr_out, a);
      end
    end
    @(negedge clk);
    checks++;
    if (req_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== (32'h200 ^ KEY)) begin
      failures++;
      $display("FAIL discard_data: got req_out=%b pc=%h instr=%h want 1 00000200 %h",
               req_out, pc_out, instr_out, 32'h200 ^ KEY);
    end
    exp_q.push_back({32'h200 ^ KEY, 32'h200});
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      failures++;
      $display("FAIL discard_count: got %0d accepted want %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++; $display("FAIL discard_sb: got nothing want instr/pc %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin failures++; $display("FAIL discard_sb: got instr/pc %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_q.size();
    $display("test_branch_discard done");
  endtask

  task automatic test_misaligned_wrap();
    apply_reset();
    mem_on = 1'b1;
    @(negedge clk);
    @(negedge clk);                       // HOLD
    branch_in = 1'b1; branch_target_in = 32'h0000_0302;
    @(negedge clk);
    branch_in = 1'b0;
    checks++;
    if (misaligned_out !== 1'b1 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h300) begin
      failures++;
      $display("FAIL mis_pulse: got mis=%b req=%b addr=%h want 1 1 00000300", misaligned_out, imem_req_out, imem_addr_out);
    end
    @(negedge clk);
    checks++;
    if (misaligned_out !== 1'b0 || req_out !== 1'b1 || pc_out !== 32'h300) begin
      failures++;
      $display("FAIL mis_clear: got mis=%b req_out=%b pc=%h want 0 1 00000300", misaligned_out, req_out, pc_out);
    end
    branch_in = 1'b1; branch_target_in = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_in = 1'b0;
    checks++;
    if (misaligned_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top: got mis=%b req=%b addr=%h want 0 1 fffffffc", misaligned_out, imem_req_out, imem_addr_out);
    end
    @(negedge clk);
    checks++;
    if (req_out !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_hold: got req_out=%b pc=%h want 1 fffffffc", req_out, pc_out);
    end
    exp_q.push_back({32'hFFFF_FFFC ^ KEY, 32'hFFFF_FFFC});
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      failures++; $display("FAIL wrap_zero: got req=%b addr=%h want 1 00000000", imem_req_out, imem_addr_out);
    end
    @(negedge clk);
    exp_q.push_back({32'h0 ^ KEY, 32'h0});
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      failures++;
      $display("FAIL wrap_count: got %0d accepted want %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++; $display("FAIL wrap_sb: got nothing want instr/pc %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin failures++; $display("FAIL wrap_sb: got instr/pc %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_q.size();
    $display("test_misaligned_wrap done");
  endtask

  task automatic test_reset_discard();
    apply_reset();
    mem_on = 1'b1;
    @(negedge clk);                       // FETCH 0
    @(negedge clk);                       // HOLD 0
    exp_q.push_back({32'h0 ^ KEY, 32'h0});
    ack_in = 1'b1;
    @(negedge clk);                       // FETCH 4
    exp_q.push_back({32'h4 ^ KEY, 32'h4});
    @(negedge clk);                       // HOLD 4, accepted at next edge
    mem_lat = 5;
    @(negedge clk);                       // FETCH 8, slow memory
    ack_in = 1'b0;
    branch_in = 1'b1; branch_target_in = 32'h0000_0503;
    @(negedge clk);                       // DISCARD
    branch_in = 1'b0;
    checks++;
    if (misaligned_out !== 1'b1 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h8 || pc_out !== 32'h4) begin
      failures++;
      $display("FAIL rstd_pre: got mis=%b req=%b addr=%h pc=%h want 1 1 00000008 00000004",
               misaligned_out, imem_req_out, imem_addr_out, pc_out);
    end
    reset = 1'b1; mem_on = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h0 || req_out !== 1'b0 ||
        instr_out !== NOP || pc_out !== 32'h0 || misaligned_out !== 1'b0) begin
      failures++;
      $display("FAIL rstd_values: got req=%b addr=%h req_out=%b instr=%h pc=%h mis=%b want 0 00000000 0 %h 00000000 0",
               imem_req_out, imem_addr_out, req_out, instr_out, pc_out, misaligned_out, NOP);
    end
    reset = 1'b0; force_ack = 1'b1;       // late ack lands in the IDLE cycle
    @(negedge clk);
    force_ack = 1'b0; mem_on = 1'b1; mem_lat = 0;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0 || req_out !== 1'b0 || instr_out !== NOP) begin
      failures++;
      $display("FAIL rstd_first_fetch: got req=%b addr=%h req_out=%b instr=%h want 1 00000000 0 %h",
               imem_req_out, imem_addr_out, req_out, instr_out, NOP);
    end
    @(negedge clk);
    checks++;
    if (req_out !== 1'b1 || pc_out !== 32'h0 || instr_out !== KEY) begin
      failures++;
      $display("FAIL rstd_data: got req_out=%b pc=%h instr=%h want 1 00000000 %h", req_out, pc_out, instr_out, KEY);
    end
    exp_q.push_back({32'h0 ^ KEY, 32'h0});
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      failures++;
      $display("FAIL rstd_count: got %0d accepted want %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++; $display("FAIL rstd_sb: got nothing want instr/pc %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin failures++; $display("FAIL rstd_sb: got instr/pc %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_q.size();
    $display("test_reset_discard done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_hold();
    test_branch_discard();
    test_misaligned_wrap();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; producer side of the req/ack handshake consumed by the decode stage.
- Holds the PC and issues word reads to instruction memory over a req/ack bus.
- Presents each fetched instruction and its PC to decode, and holds it until decode acknowledges.
- Handles branch/jump redirects from execute by squashing in-flight or held instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr_out when no instruction is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_out  output  1  instruction memory read request
imem_addr_out  output  32  word-aligned read address
imem_ack_in  input  1  memory read complete; imem_rdata_in valid this cycle
imem_rdata_in  input  32  instruction word from memory
req_out  output  1  instruction valid toward decode
ack_in  input  1  decode has accepted instr_out/pc_out
stall_in  input  1  pipeline stall; decode acceptance ignored while high
instr_out  output  32  instruction to decode
pc_out  output  32  PC of instr_out
branch_in  input  1  redirect request from execute, single-cycle pulse
branch_target_in  input  32  redirect target, sampled when branch_in=1
misaligned_out  output  1  one-cycle pulse: redirect target had bits[1:0]!=0

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - imem_req_out=0; imem_addr_out=RESET_PC.
  - req_out=0; instr_out=NOP_INSTR; pc_out=0; misaligned_out=0.
  - Reset asserted in any state, including mid memory request, abandons all activity. A memory ack arriving in the cycle after reset deassertion is ignored, because the block is in IDLE.
- IDLE: next cycle goes to FETCH.
- FETCH: imem_req_out=1, imem_addr_out=pc.
  - Address is held stable until imem_ack_in.
  - imem_ack_in=1 and branch_in=0: instr_out<=imem_rdata_in, pc_out<=pc, pc<=pc+4, req_out<=1, go to HOLD.
  - branch_in=1 and imem_ack_in=1: data is dropped, pc<=target, stay in FETCH. The new address appears next cycle.
  - branch_in=1 and imem_ack_in=0: pc<=target, go to DISCARD. imem_req_out and the old address are held until the outstanding ack.
- HOLD: req_out=1; instr_out and pc_out are stable; imem_req_out=0.
  - branch_in=1: highest priority. req_out<=0, instr_out<=NOP_INSTR, pc<=target, go to FETCH. Decode ack in the same cycle is ignored, so the instruction is squashed.
  - ack_in=1 and stall_in=0: req_out<=0, instr_out<=NOP_INSTR, go to FETCH.
  - ack_in=1 and stall_in=1: no effect; remain in HOLD.
- DISCARD: imem_req_out=1 with the stale address.
  - On imem_ack_in: data is dropped, go to FETCH at the redirected pc.
  - A second branch_in while in DISCARD overwrites pc with the newest target; remain in DISCARD.
- Redirect alignment:
  - pc loads {branch_target_in[31:2],2'b00}.
  - misaligned_out=1 in the cycle after any accepted branch_in whose target[1:0]!=0; otherwise 0.
  - branch_in is accepted in every state except IDLE, where it is ignored.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). pc[1:0] is always 0.
- Timing:
  - Minimum latency from FETCH entry to req_out=1 is 1 cycle (ack in first FETCH cycle).
  - Peak throughput is one instruction per 2 cycles (FETCH, HOLD).
  - Outputs are registered; no combinational path from inputs to req_out, instr_out or pc_out.
- At most one memory request is outstanding at any time; no request is issued in HOLD.

Test Plan:
- Reset then zero-wait memory returning rdata=addr^32'hA5A5_0000, ack_in tied 1 -> imem_addr_out 0,4,8,C in successive FETCH cycles; pc_out/instr_out pairs match; req_out high every 2nd cycle.
- Decode withholds ack 5 cycles, then stall_in=1 with ack_in=1 for 2 cycles, then releases -> instr_out/pc_out stable throughout; no imem_req_out; next fetch at pc_out+4 only after the unstalled ack.
- branch_in target 32'h0000_0100 while in HOLD with ack_in=1 same cycle -> req_out drops, instr_out=NOP_INSTR, next imem_addr_out=32'h100; held instruction never accepted.
- Memory ack delayed 3 cycles, branch_in target 32'h200 in FETCH cycle 1 -> imem_addr_out holds old address until ack, data dropped, next request address 32'h200, req_out stays 0 until 32'h200 data arrives.
- branch_in target 32'h0000_0302 -> misaligned_out pulses 1 cycle, next fetch address 32'h300; target 32'hFFFF_FFFC then sequential fetch -> addresses FFFF_FFFC then 0000_0000.
- reset asserted mid-DISCARD with pending ack -> all outputs at reset values next cycle; late ack ignored; first fetch from RESET_PC.
